// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: three-state issue/writeback control around an external 8-bit combinational ALU.
// One op per 3 cycles, no buffering; `define IMM_OPERAND_EN adds an immediate B operand.
module alu_op_sequencer #(
  parameter int NREGS = 8,
  parameter int DW    = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [2:0]    cmd_op,
  input  logic [2:0]    cmd_dst,
  input  logic [2:0]    cmd_srca,
  input  logic [2:0]    cmd_srcb,
`ifdef IMM_OPERAND_EN
  input  logic          cmd_imm_sel,
  input  logic [DW-1:0] cmd_imm,
`endif
  output logic [DW-1:0] alu_a,
  output logic [DW-1:0] alu_b,
  output logic [2:0]    alu_n,
  input  logic [DW-1:0] alu_r,
  input  logic [3:0]    alu_cc,
  output logic [3:0]    cc_q,
  output logic          done,
  input  logic [2:0]    rd_addr,
  output logic [DW-1:0] rd_data
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WB    = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_next_state;
  logic          w_accept;
  logic [DW-1:0] w_opb;

  logic [DW-1:0] r_rf [NREGS];
  logic [2:0]    r_dst;
  logic [DW-1:0] r_alu_a;
  logic [DW-1:0] r_alu_b;
  logic [2:0]    r_alu_n;
  logic [DW-1:0] r_result;
  logic [3:0]    r_cc_stage;
  logic [3:0]    r_cc_q;
  logic          r_done;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_next_state = S_ISSUE;
      S_ISSUE: w_next_state = S_WB;
      S_WB:    w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_comb begin
    cmd_ready = (r_state == S_IDLE);
  end

  assign w_accept = cmd_valid && cmd_ready;

`ifdef IMM_OPERAND_EN
  assign w_opb = cmd_imm_sel ? cmd_imm : r_rf[cmd_srcb];
`else
  assign w_opb = r_rf[cmd_srcb];
`endif

  // ALU drive registers only move on accept, so the ALU inputs stay quiet otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        r_rf[i] <= '0;
      end
      r_dst      <= '0;
      r_alu_a    <= '0;
      r_alu_b    <= '0;
      r_alu_n    <= '0;
      r_result   <= '0;
      r_cc_stage <= '0;
      r_cc_q     <= '0;
      r_done     <= 1'b0;
    end else begin
      r_done <= (r_state == S_WB);
      if (w_accept) begin
        r_dst   <= cmd_dst;
        r_alu_a <= r_rf[cmd_srca];
        r_alu_b <= w_opb;
        r_alu_n <= cmd_op;
      end
      if (r_state == S_ISSUE) begin
        r_result   <= alu_r;
        r_cc_stage <= alu_cc;
      end
      if (r_state == S_WB) begin
        r_rf[r_dst] <= r_result;
        r_cc_q      <= r_cc_stage;
      end
    end
  end

  assign alu_a   = r_alu_a;
  assign alu_b   = r_alu_b;
  assign alu_n   = r_alu_n;
  assign cc_q    = r_cc_q;
  assign done    = r_done;
  assign rd_data = r_rf[rd_addr];

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with an adder ALU model; opcode 7 of the model
// returns a bench constant so registers can be preloaded when IMM_OPERAND_EN is absent.
module tb_alu_op_sequencer;

  logic       clk;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_op;
  logic [2:0] cmd_dst;
  logic [2:0] cmd_srca;
  logic [2:0] cmd_srcb;
  logic       cmd_imm_sel;
  logic [7:0] cmd_imm;
  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic [2:0] alu_n;
  logic [7:0] alu_r;
  logic [3:0] alu_cc;
  logic [3:0] cc_q;
  logic       done;
  logic [2:0] rd_addr;
  logic [7:0] rd_data;

  logic [7:0] tb_const;
  logic [8:0] w_sum;

  int checks = 0;
  int errors = 0;

  alu_op_sequencer #(.NREGS(8), .DW(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_dst    (cmd_dst),
    .cmd_srca   (cmd_srca),
    .cmd_srcb   (cmd_srcb),
`ifdef IMM_OPERAND_EN
    .cmd_imm_sel(cmd_imm_sel),
    .cmd_imm    (cmd_imm),
`endif
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_n      (alu_n),
    .alu_r      (alu_r),
    .alu_cc     (alu_cc),
    .cc_q       (cc_q),
    .done       (done),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data)
  );

  // ALU model: add with {carry, zero, neg, 0}; opcode 7 loads tb_const.
  assign w_sum  = {1'b0, alu_a} + {1'b0, alu_b};
  assign alu_r  = (alu_n == 3'd7) ? tb_const : w_sum[7:0];
  assign alu_cc = (alu_n == 3'd7) ? {1'b0, tb_const == 8'h00, tb_const[7], 1'b0}
                                  : {w_sum[8], w_sum[7:0] == 8'h00, w_sum[7], 1'b0};

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic rdchk(input string tag, input logic [2:0] addr, input logic [7:0] exp);
    rd_addr = addr;
    #1;
    chk(tag, 32'(rd_data), 32'(exp));
  endtask

  // Presents one command and clocks it in; returns just after the accept edge.
  task automatic issue(input logic [2:0] op, input logic [2:0] dst, input logic [2:0] sa,
                       input logic [2:0] sb, input logic isel, input logic [7:0] imm);
    chk("ready_before_issue", 32'(cmd_ready), 32'd1);
    cmd_valid   = 1'b1;
    cmd_op      = op;
    cmd_dst     = dst;
    cmd_srca    = sa;
    cmd_srcb    = sb;
    cmd_imm_sel = isel;
    cmd_imm     = imm;
    tick();
    cmd_valid   = 1'b0;
    cmd_imm_sel = 1'b0;
  endtask

  // Writes val into rf[dst]; returns in the done cycle.
  task automatic preload(input logic [2:0] dst, input logic [7:0] val);
`ifdef IMM_OPERAND_EN
    issue(3'd0, dst, 3'd0, 3'd6, 1'b1, val);
`else
    tb_const = val;
    issue(3'd7, dst, 3'd0, 3'd0, 1'b0, 8'h00);
`endif
    tick();
    tick();
  endtask

  initial begin
    int low;
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_dst = '0; cmd_srca = '0; cmd_srcb = '0;
    cmd_imm_sel = 1'b0; cmd_imm = '0; rd_addr = '0; tb_const = '0;
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    for (int i = 0; i < 8; i++) begin
      rdchk("rst_rf", 3'(i), 8'h00);
    end
    chk("rst_ready", 32'(cmd_ready), 32'd1);
    chk("rst_cc_q", 32'(cc_q), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_alu_a", 32'(alu_a), 32'd0);
    chk("rst_alu_n", 32'(alu_n), 32'd0);

    // r3 = r1 + r2 = 0x05 + 0x0A
    preload(3'd1, 8'h05);
    preload(3'd2, 8'h0A);
    rdchk("pre_r1", 3'd1, 8'h05);
    rdchk("pre_r2", 3'd2, 8'h0A);
    issue(3'd0, 3'd3, 3'd1, 3'd2, 1'b0, 8'h00);
    chk("add_alu_a", 32'(alu_a), 32'h05);
    chk("add_alu_b", 32'(alu_b), 32'h0A);
    chk("add_alu_n", 32'(alu_n), 32'd0);
    chk("add_ready_issue", 32'(cmd_ready), 32'd0);
    chk("add_done_issue", 32'(done), 32'd0);
    tick();
    chk("add_ready_wb", 32'(cmd_ready), 32'd0);
    chk("add_done_wb", 32'(done), 32'd0);
    rdchk("add_r3_before_wb", 3'd3, 8'h00);
    tick();
    chk("add_done", 32'(done), 32'd1);
    chk("add_ready_after", 32'(cmd_ready), 32'd1);
    chk("add_cc_q", 32'(cc_q), 32'h0);
    rdchk("add_r3", 3'd3, 8'h0F);
    tick();
    chk("add_done_drop", 32'(done), 32'd0);
    chk("add_alu_a_hold", 32'(alu_a), 32'h05);
    chk("add_alu_b_hold", 32'(alu_b), 32'h0A);

    // r6 = 0xFF + 0x01 wraps to zero with carry
    preload(3'd4, 8'hFF);
    preload(3'd5, 8'h01);
    issue(3'd0, 3'd6, 3'd4, 3'd5, 1'b0, 8'h00);
    tick();
    tick();
    chk("wrap_done", 32'(done), 32'd1);
    rdchk("wrap_r6", 3'd6, 8'h00);
    chk("wrap_cc_q", 32'(cc_q), 32'hC);

    // Back-to-back with valid held: A r4=r3+r1=0x14, B r5=r4+r4=0x28
    issue(3'd0, 3'd4, 3'd3, 3'd1, 1'b0, 8'h00);
    cmd_valid = 1'b1; cmd_op = 3'd0; cmd_dst = 3'd5; cmd_srca = 3'd4; cmd_srcb = 3'd4;
    low = 0;
    for (int n = 0; n < 10; n++) begin
      if (cmd_ready) break;
      low++;
      tick();
    end
    chk("b2b_ready_low_cycles", 32'(low), 32'd2);
    chk("b2b_done_a", 32'(done), 32'd1);
    rdchk("b2b_r4", 3'd4, 8'h14);
    tick();
    cmd_valid = 1'b0;
    chk("b2b_alu_a", 32'(alu_a), 32'h14);
    chk("b2b_alu_b", 32'(alu_b), 32'h14);
    tick();
    tick();
    chk("b2b_done_b", 32'(done), 32'd1);
    rdchk("b2b_r5", 3'd5, 8'h28);
    chk("b2b_cc_q", 32'(cc_q), 32'h0);

    // Reset during ISSUE of r7 = r1 + r2
    issue(3'd0, 3'd7, 3'd1, 3'd2, 1'b0, 8'h00);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_ready", 32'(cmd_ready), 32'd1);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_alu_a", 32'(alu_a), 32'd0);
    chk("abort_cc_q", 32'(cc_q), 32'd0);
    rdchk("abort_r7", 3'd7, 8'h00);
    rdchk("abort_r1", 3'd1, 8'h00);
    tick();
    chk("abort_done_later", 32'(done), 32'd0);
    chk("abort_ready_later", 32'(cmd_ready), 32'd1);
    tick();
    rdchk("abort_r7_later", 3'd7, 8'h00);

    // Command offered while busy is ignored
    preload(3'd1, 8'h33);
    issue(3'd0, 3'd2, 3'd1, 3'd1, 1'b0, 8'h00);
    cmd_valid = 1'b1; cmd_op = 3'd5; cmd_dst = 3'd3; cmd_srca = 3'd1; cmd_srcb = 3'd2;
    tick();
    chk("busy_alu_n", 32'(alu_n), 32'd0);
    chk("busy_ready", 32'(cmd_ready), 32'd0);
    tick();
    cmd_valid = 1'b0;
    chk("busy_done", 32'(done), 32'd1);
    rdchk("busy_r2", 3'd2, 8'h66);
    chk("busy_alu_a_hold", 32'(alu_a), 32'h33);
    tick();
    chk("busy_done_drop", 32'(done), 32'd0);
    tick();
    tick();
    chk("busy_no_extra_done", 32'(done), 32'd0);
    rdchk("busy_r3", 3'd3, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
